// File: rtl/bp_pkg.sv
// Shared types, constants and index helpers for the multi-lane branch predictor.
// Provides the counter type, BTB entry layout, indexing modes and PC/history hash functions.
package bp_pkg;

    typedef logic [1:0] cnt_t;

    localparam cnt_t CNT_MIN = 2'b00;
    localparam cnt_t CNT_WNT = 2'b01;
    localparam cnt_t CNT_MAX = 2'b11;

    localparam int MODE_GSELECT = 0;
    localparam int MODE_GSHARE  = 1;

    // Tag kept at full word-address width; bits above the live tag stay zero.
    typedef struct packed {
        logic        valid;
        logic [29:0] tag;
        logic [31:0] target;
    } btb_entry_t;

    function automatic logic [31:0] lo_mask(input int w);
        return (32'd1 << w) - 32'd1;
    endfunction

    // gselect: {ghr, pc bits}; gshare: pc bits ^ ghr.
    function automatic logic [31:0] pht_idx(
        input logic [31:0] pc,
        input logic [31:0] ghr,
        input int          mode,
        input int          ghr_w,
        input int          pc_idx_w
    );
        logic [31:0] word;
        word = pc >> 2;
        if (mode == MODE_GSHARE)
            return (word ^ ghr) & lo_mask(ghr_w);
        return ((ghr & lo_mask(ghr_w)) << pc_idx_w) | (word & lo_mask(pc_idx_w));
    endfunction

    function automatic logic [31:0] btb_index(input logic [31:0] pc, input int idx_w);
        return (pc >> 2) & lo_mask(idx_w);
    endfunction

    function automatic logic [29:0] btb_tag(input logic [31:0] pc, input int idx_w);
        return 30'(pc >> (idx_w + 2));
    endfunction

endpackage

// File: rtl/bp_sat_counter2.sv
// Combinational 2-bit saturating counter step.
// Ports: cnt (current), taken (direction) -> cnt_next.
module bp_sat_counter2
    import bp_pkg::*;
(
    input  cnt_t cnt,
    input  logic taken,
    output cnt_t cnt_next
);

    always_comb begin
        cnt_next = cnt;
        if (taken && cnt != CNT_MAX)
            cnt_next = cnt + 2'd1;
        else if (!taken && cnt != CNT_MIN)
            cnt_next = cnt - 2'd1;
    end

endmodule

// File: rtl/branch_predictor_gselect_mp.sv
// Multi-lane global-history branch predictor (PHT + tagged direct-mapped BTB).
// Ports: clk, rst (async active-low); pred_valid/pred_pc in, target/pred_taken/btb_hit/target_valid
// out one cycle later; train_valid/isbranch/pc/target/taken commit updates in lane order.
module branch_predictor_gselect_mp
    import bp_pkg::*;
#(
    parameter int NLANE     = 2,
    parameter int GHR_W     = 4,
    parameter int PC_IDX_W  = 4,
    parameter int BTB_IDX_W = 5,
    parameter int MODE      = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NLANE-1:0]    pred_valid,
    input  logic [NLANE*32-1:0] pred_pc,
    output logic [NLANE*32-1:0] target,
    output logic [NLANE-1:0]    pred_taken,
    output logic [NLANE-1:0]    btb_hit,
    output logic [NLANE-1:0]    target_valid,
    input  logic [NLANE-1:0]    train_valid,
    input  logic [NLANE-1:0]    train_isbranch,
    input  logic [NLANE*32-1:0] train_pc,
    input  logic [NLANE*32-1:0] train_target,
    input  logic [NLANE-1:0]    train_taken
);

    localparam int PHT_W = (MODE == MODE_GSHARE) ? GHR_W : GHR_W + PC_IDX_W;
    localparam int PHT_D = 1 << PHT_W;
    localparam int BTB_D = 1 << BTB_IDX_W;

    logic [GHR_W-1:0] ghr;
    logic [GHR_W-1:0] ghr_nxt;
    cnt_t             pht [PHT_D];
    btb_entry_t       btb [BTB_D];

    logic [NLANE-1:0]    p_tk;
    logic [NLANE-1:0]    p_hit;
    logic [NLANE*32-1:0] p_tgt;

    logic [NLANE-1:0]     t_upd;
    logic [PHT_W-1:0]     t_idx  [NLANE];
    cnt_t                 t_cnt  [NLANE];
    logic [BTB_IDX_W-1:0] t_bidx [NLANE];
    btb_entry_t           t_ent  [NLANE];

    // Prediction reads pre-update state; no bypass from training.
    always_comb begin
        logic [31:0] pc;
        btb_entry_t  e;
        pc    = '0;
        e     = '0;
        p_tk  = '0;
        p_hit = '0;
        p_tgt = '0;
        for (int i = 0; i < NLANE; i++) begin
            pc       = pred_pc[32*i +: 32];
            e        = btb[BTB_IDX_W'(btb_index(pc, BTB_IDX_W))];
            p_tk[i]  = pht[PHT_W'(pht_idx(pc, 32'(ghr), MODE, GHR_W, PC_IDX_W))][1];
            p_hit[i] = e.valid && (e.tag == btb_tag(pc, BTB_IDX_W));
            p_tgt[32*i +: 32] = (p_tk[i] && p_hit[i]) ? e.target : pc + 32'd4;
        end
    end

    // Each lane sees the history shifted by the lanes before it, and a
    // counter already advanced by any earlier lane that hit the same entry.
    for (genvar k = 0; k < NLANE; k++) begin : g_trn
        logic [31:0]      pc;
        logic             upd;
        logic             tk;
        logic [GHR_W-1:0] g_in;
        logic [GHR_W-1:0] g_out;
        logic [PHT_W-1:0] idx;
        cnt_t             cnt_in;
        cnt_t             cnt_nxt;

        assign pc  = train_pc[32*k +: 32];
        assign tk  = train_taken[k];
        assign upd = train_valid[k] & train_isbranch[k];

        if (k == 0) begin : g_head
            assign g_in = ghr;
        end else begin : g_link
            assign g_in = g_trn[k-1].g_out;
        end

        assign g_out = upd ? GHR_W'({g_in, tk}) : g_in;
        assign idx   = PHT_W'(pht_idx(pc, 32'(g_in), MODE, GHR_W, PC_IDX_W));

        for (genvar j = 0; j < k; j++) begin : g_fwd
            cnt_t prev;
            cnt_t v;
            if (j == 0) begin : g_base
                assign prev = pht[idx];
            end else begin : g_chain
                assign prev = g_fwd[j-1].v;
            end
            assign v = (g_trn[j].upd && g_trn[j].idx == idx) ? g_trn[j].cnt_nxt : prev;
        end

        if (k == 0) begin : g_rd
            assign cnt_in = pht[idx];
        end else begin : g_rdf
            assign cnt_in = g_fwd[k-1].v;
        end

        bp_sat_counter2 u_cnt (
            .cnt      (cnt_in),
            .taken    (tk),
            .cnt_next (cnt_nxt)
        );

        assign t_upd[k]  = upd;
        assign t_idx[k]  = idx;
        assign t_cnt[k]  = cnt_nxt;
        assign t_bidx[k] = BTB_IDX_W'(btb_index(pc, BTB_IDX_W));
        assign t_ent[k]  = '{valid:  1'b1,
                             tag:    btb_tag(pc, BTB_IDX_W),
                             target: train_target[32*k +: 32]};
    end

    assign ghr_nxt = g_trn[NLANE-1].g_out;

    // Lane order: a later lane's write to the same entry wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ghr <= '0;
            for (int e = 0; e < PHT_D; e++)
                pht[e] <= CNT_WNT;
            for (int e = 0; e < BTB_D; e++)
                btb[e] <= '0;
        end else begin
            ghr <= ghr_nxt;
            for (int k = 0; k < NLANE; k++) begin
                if (t_upd[k]) begin
                    pht[t_idx[k]] <= t_cnt[k];
                    if (train_taken[k])
                        btb[t_bidx[k]] <= t_ent[k];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            target       <= '0;
            pred_taken   <= '0;
            btb_hit      <= '0;
            target_valid <= '0;
        end else begin
            target_valid <= pred_valid;
            for (int i = 0; i < NLANE; i++) begin
                if (pred_valid[i]) begin
                    target[32*i +: 32] <= p_tgt[32*i +: 32];
                    pred_taken[i]      <= p_tk[i];
                    btb_hit[i]         <= p_hit[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor_gselect_mp.sv
// Self-checking bench for branch_predictor_gselect_mp (NLANE=2, gselect defaults).
// Behavioural model feeds a scoreboard queue; directed scenarios add fixed-value checks.
module tb_branch_predictor_gselect_mp;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  pred_valid;
    logic [63:0] pred_pc;
    logic [63:0] target;
    logic [1:0]  pred_taken;
    logic [1:0]  btb_hit;
    logic [1:0]  target_valid;
    logic [1:0]  train_valid;
    logic [1:0]  train_isbranch;
    logic [63:0] train_pc;
    logic [63:0] train_target;
    logic [1:0]  train_taken;

    int n_chk = 0;
    int n_err = 0;

    branch_predictor_gselect_mp dut (
        .clk            (clk),
        .rst            (rst),
        .pred_valid     (pred_valid),
        .pred_pc        (pred_pc),
        .target         (target),
        .pred_taken     (pred_taken),
        .btb_hit        (btb_hit),
        .target_valid   (target_valid),
        .train_valid    (train_valid),
        .train_isbranch (train_isbranch),
        .train_pc       (train_pc),
        .train_target   (train_target),
        .train_taken    (train_taken)
    );

    always #5 clk = ~clk;

    // model state
    bit [1:0]  m_pht [256];
    bit        m_v   [32];
    bit [24:0] m_tag [32];
    bit [31:0] m_tgt [32];
    bit [3:0]  m_ghr;
    bit        h_tk  [2];
    bit        h_hit [2];
    bit [31:0] h_tgt [2];

    typedef struct {
        int        lane;
        bit        tv;
        bit        tk;
        bit        hit;
        bit [31:0] tgt;
    } exp_t;

    exp_t sbq [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < 256; i++) m_pht[i] = 2'b01;
        for (int i = 0; i < 32; i++) begin
            m_v[i]   = 1'b0;
            m_tag[i] = '0;
            m_tgt[i] = '0;
        end
        m_ghr = '0;
        for (int l = 0; l < 2; l++) begin
            h_tk[l]  = 1'b0;
            h_hit[l] = 1'b0;
            h_tgt[l] = '0;
        end
        sbq.delete();
    endtask

    task automatic clr();
        pred_valid     = '0;
        pred_pc        = '0;
        train_valid    = '0;
        train_isbranch = '0;
        train_pc       = '0;
        train_target   = '0;
        train_taken    = '0;
    endtask

    task automatic drv_pred(input int l, input logic [31:0] pc);
        pred_valid[l]       = 1'b1;
        pred_pc[32*l +: 32] = pc;
    endtask

    task automatic drv_train(input int l, input logic [31:0] pc, input logic [31:0] tgt,
                             input bit tk, input bit br);
        train_valid[l]           = 1'b1;
        train_isbranch[l]        = br;
        train_pc[32*l +: 32]     = pc;
        train_target[32*l +: 32] = tgt;
        train_taken[l]           = tk;
    endtask

    // One clock: push expectations from pre-edge model, commit training, compare.
    task automatic cycle();
        logic [31:0] pc;
        bit   [7:0]  pi;
        bit   [4:0]  bi;
        bit          tk;
        exp_t        e;
        for (int l = 0; l < 2; l++) begin
            if (pred_valid[l]) begin
                pc       = pred_pc[32*l +: 32];
                pi       = {m_ghr, pc[5:2]};
                bi       = pc[6:2];
                h_tk[l]  = m_pht[pi][1];
                h_hit[l] = m_v[bi] && (m_tag[bi] == pc[31:7]);
                h_tgt[l] = (h_tk[l] && h_hit[l]) ? m_tgt[bi] : pc + 32'd4;
            end
            sbq.push_back('{l, pred_valid[l], h_tk[l], h_hit[l], h_tgt[l]});
        end
        @(posedge clk);
        for (int l = 0; l < 2; l++) begin
            if (train_valid[l] && train_isbranch[l]) begin
                pc = train_pc[32*l +: 32];
                tk = train_taken[l];
                pi = {m_ghr, pc[5:2]};
                bi = pc[6:2];
                if (tk && m_pht[pi] != 2'd3)
                    m_pht[pi] = m_pht[pi] + 2'd1;
                else if (!tk && m_pht[pi] != 2'd0)
                    m_pht[pi] = m_pht[pi] - 2'd1;
                m_ghr = {m_ghr[2:0], tk};
                if (tk) begin
                    m_v[bi]   = 1'b1;
                    m_tag[bi] = pc[31:7];
                    m_tgt[bi] = train_target[32*l +: 32];
                end
            end
        end
        #1;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk($sformatf("tv%0d", e.lane), 32'(target_valid[e.lane]), 32'(e.tv));
            chk($sformatf("tk%0d", e.lane), 32'(pred_taken[e.lane]), 32'(e.tk));
            chk($sformatf("hit%0d", e.lane), 32'(btb_hit[e.lane]), 32'(e.hit));
            chk($sformatf("tgt%0d", e.lane), target[32*e.lane +: 32], e.tgt);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not end");
        $fatal(1);
    end

    initial begin
        clr();
        m_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_tv", 32'(target_valid), 32'd0);
        chk("reset_tk", 32'(pred_taken), 32'd0);
        chk("reset_hit", 32'(btb_hit), 32'd0);
        chk("reset_tgt0", target[31:0], 32'd0);
        chk("reset_tgt1", target[63:32], 32'd0);
        rst = 1'b1;

        // basic post-reset prediction
        drv_pred(0, 32'h100);
        cycle();
        chk("t1_tgt", target[31:0], 32'h104);
        chk("t1_tk", 32'(pred_taken[0]), 32'd0);
        chk("t1_tv", 32'(target_valid[0]), 32'd1);

        // repeated taken training until history saturates at 1111
        clr();
        for (int n = 0; n < 9; n++) begin
            drv_train(0, 32'h100, 32'h200, 1'b1, 1'b1);
            cycle();
        end
        clr();
        drv_pred(0, 32'h100);
        cycle();
        chk("t2_tk", 32'(pred_taken[0]), 32'd1);
        chk("t2_hit", 32'(btb_hit[0]), 32'd1);
        chk("t2_tgt", target[31:0], 32'h200);

        // saturated 3 -> not-taken -> 2 still predicts taken
        clr();
        drv_train(0, 32'h100, 32'h200, 1'b0, 1'b1);
        cycle();
        for (int n = 0; n < 4; n++) begin
            clr();
            drv_train(0, 32'h104, 32'h250, 1'b1, 1'b1);
            cycle();
        end
        clr();
        drv_pred(0, 32'h100);
        cycle();
        chk("t3_tk", 32'(pred_taken[0]), 32'd1);
        chk("t3_tgt", target[31:0], 32'h200);

        // dual-lane collision: counter 1 -> 3, lane1 target kept
        clr();
        drv_train(0, 32'h148, 32'h300, 1'b1, 1'b1);
        drv_train(1, 32'h148, 32'h400, 1'b1, 1'b1);
        cycle();
        clr();
        drv_pred(0, 32'h148);
        cycle();
        chk("t4_tgt", target[31:0], 32'h400);
        clr();
        drv_train(0, 32'h148, 32'h400, 1'b0, 1'b1);
        cycle();
        for (int n = 0; n < 4; n++) begin
            clr();
            drv_train(0, 32'h104, 32'h250, 1'b1, 1'b1);
            cycle();
        end
        clr();
        drv_pred(1, 32'h148);
        cycle();
        chk("t4_cum_tk", 32'(pred_taken[1]), 32'd1);
        chk("t4_cum_tgt", target[63:32], 32'h400);

        // wrap of pc+4, both lanes predicting
        clr();
        drv_pred(0, 32'h100);
        drv_pred(1, 32'hFFFF_FFFC);
        cycle();
        chk("t5_wrap", target[63:32], 32'h0);
        chk("t5_lane0", target[31:0], 32'h200);

        // non-branch training is ignored
        clr();
        drv_train(0, 32'h180, 32'h500, 1'b1, 1'b0);
        cycle();
        clr();
        drv_pred(0, 32'h180);
        cycle();
        chk("nb_hit", 32'(btb_hit[0]), 32'd0);
        chk("nb_tgt", target[31:0], 32'h184);

        // predict and train same entry in one cycle: old state seen
        clr();
        drv_train(1, 32'h1C0, 32'h600, 1'b1, 1'b1);
        drv_pred(0, 32'h1C0);
        cycle();
        chk("same_hit", 32'(btb_hit[0]), 32'd0);
        chk("same_tgt", target[31:0], 32'h1C4);
        clr();
        drv_pred(0, 32'h1C0);
        cycle();
        chk("after_tgt", target[31:0], 32'h600);

        // random mixed traffic
        for (int n = 0; n < 200; n++) begin
            clr();
            for (int l = 0; l < 2; l++) begin
                if ($urandom_range(0, 1) == 1)
                    drv_pred(l, 32'h100 + 32'($urandom_range(0, 31)) * 4);
                if ($urandom_range(0, 2) != 0)
                    drv_train(l, 32'h100 + 32'($urandom_range(0, 31)) * 4,
                              32'h1000 + 32'($urandom_range(0, 255)) * 4,
                              1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
            end
            cycle();
        end

        // mid-stream asynchronous reset
        clr();
        drv_pred(0, 32'h100);
        drv_pred(1, 32'h148);
        cycle();
        #3;
        rst = 1'b0;
        #1;
        chk("arst_tv", 32'(target_valid), 32'd0);
        chk("arst_tk", 32'(pred_taken), 32'd0);
        chk("arst_hit", 32'(btb_hit), 32'd0);
        chk("arst_tgt0", target[31:0], 32'd0);
        m_reset();
        @(posedge clk);
        #1;
        chk("arst_hold_tv", 32'(target_valid), 32'd0);
        rst = 1'b1;
        cycle();
        chk("post_tk", 32'(pred_taken[0]), 32'd0);
        chk("post_hit", 32'(btb_hit[0]), 32'd0);
        chk("post_tgt", target[31:0], 32'h104);
        chk("post_tgt1", target[63:32], 32'h14C);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
